// File: rtl/bcd_keystroke_player.sv
// bcd_keystroke_player
// Converts a binary value (0-99) to two BCD digits and replays it as the
// keystroke sequence a 2-digit sentence builder expects: clear, tens, ones.
// Each keystroke is set up for one cycle, strobed with new_val for
// PULSE_CYCLES cycles, then held for GAP_CYCLES cycles after new_val falls.
// Optional feature: define LEADING_ZERO_SUPPRESS_EN to skip the tens
// keystroke when the tens digit is zero.
module bcd_keystroke_player #(
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] value,
  output logic [3:0] bcd,
  output logic       key_valid,
  output logic       new_val,
  output logic       kb_reset,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_CONV      = 3'd1;
  localparam logic [2:0] S_KEY_SETUP = 3'd2;
  localparam logic [2:0] S_KEY_PULSE = 3'd3;
  localparam logic [2:0] S_KEY_HOLD  = 3'd4;
  localparam logic [2:0] S_DONE      = 3'd5;

  localparam logic [3:0] CLEAR_CODE = 4'hC;
  localparam logic [7:0] MAX_VALUE  = 8'd99;

  localparam int CNT_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);

  logic [2:0]       state, state_n;
  logic [6:0]       rem, rem_n;
  logic [3:0]       tens, tens_n;
  logic [3:0]       ones, ones_n;
  logic [1:0]       k, k_n;
  logic [CNT_W-1:0] cnt, cnt_n;

  logic [3:0] bcd_n;
  logic       key_valid_n;
  logic       new_val_n;
  logic       kb_reset_n;
  logic       busy_n;
  logic       done_n;
  logic       err_n;

  logic       key_active_n;
  logic [3:0] code_n;

  // Next-state, datapath and keystroke sequencing.
  always_comb begin
    state_n = state;
    rem_n   = rem;
    tens_n  = tens;
    ones_n  = ones;
    k_n     = k;
    cnt_n   = cnt;
    err_n   = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          rem_n  = value[6:0];
          tens_n = '0;
          if (value > MAX_VALUE) begin
            err_n = 1'b1;
          end else begin
            state_n = S_CONV;
          end
        end
      end

      S_CONV: begin
        // Repeated subtraction: one decade per cycle.
        if (rem >= 7'd10) begin
          rem_n  = rem - 7'd10;
          tens_n = tens + 4'd1;
        end else begin
          ones_n  = rem[3:0];
          k_n     = 2'd0;
          state_n = S_KEY_SETUP;
        end
      end

      S_KEY_SETUP: begin
        cnt_n   = '0;
        state_n = S_KEY_PULSE;
      end

      S_KEY_PULSE: begin
        if (cnt == PULSE_LAST) begin
          cnt_n   = '0;
          state_n = S_KEY_HOLD;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      S_KEY_HOLD: begin
        if (cnt == GAP_LAST) begin
          cnt_n = '0;
          if (k == 2'd2) begin
            state_n = S_DONE;
          end else begin
            state_n = S_KEY_SETUP;
`ifdef LEADING_ZERO_SUPPRESS_EN
            if ((k == 2'd0) && (tens == 4'd0)) begin
              k_n = 2'd2;
            end else begin
              k_n = k + 2'd1;
            end
`else
            k_n = k + 2'd1;
`endif
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      S_DONE: begin
        state_n = S_IDLE;
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // Output values decoded from the next state so the outputs are registered
  // and change in the same cycle the state does.
  always_comb begin
    key_active_n = (state_n == S_KEY_SETUP) || (state_n == S_KEY_PULSE) ||
                   (state_n == S_KEY_HOLD);
    case (k_n)
      2'd0:    code_n = CLEAR_CODE;
      2'd1:    code_n = tens_n;
      default: code_n = ones_n;
    endcase
    bcd_n       = key_active_n ? code_n : 4'd0;
    key_valid_n = key_active_n;
    kb_reset_n  = key_active_n && (k_n == 2'd0);
    new_val_n   = (state_n == S_KEY_PULSE);
    busy_n      = (state_n != S_IDLE);
    done_n      = (state_n == S_DONE);
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      rem       <= '0;
      tens      <= '0;
      ones      <= '0;
      k         <= '0;
      cnt       <= '0;
      bcd       <= '0;
      key_valid <= 1'b0;
      new_val   <= 1'b0;
      kb_reset  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      rem       <= rem_n;
      tens      <= tens_n;
      ones      <= ones_n;
      k         <= k_n;
      cnt       <= cnt_n;
      bcd       <= bcd_n;
      key_valid <= key_valid_n;
      new_val   <= new_val_n;
      kb_reset  <= kb_reset_n;
      busy      <= busy_n;
      done      <= done_n;
      err       <= err_n;
    end
  end

endmodule

// File: tb/tb_bcd_keystroke_player.sv
// Testbench for bcd_keystroke_player: directed cases plus random values,
// checked against a keystroke-list / timing model and a receiver model.
module tb_bcd_keystroke_player;

  localparam int P = 4;
  localparam int G = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] value;
  logic [3:0] bcd;
  logic       key_valid;
  logic       new_val;
  logic       kb_reset;
  logic       busy;
  logic       done;
  logic       err;

  bcd_keystroke_player #(
    .PULSE_CYCLES(P),
    .GAP_CYCLES  (G)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .value    (value),
    .bcd      (bcd),
    .key_valid(key_valid),
    .new_val  (new_val),
    .kb_reset (kb_reset),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Observation state filled in by the monitor.
  int          obs_code[$];
  int          obs_kbr[$];
  int unsigned obs_fall[$];
  int          n_rise;
  int          n_done;
  int          n_err;
  int unsigned done_cyc;
  int unsigned err_cyc;
  bit          busy_seen;
  logic [7:0]  rx;

  // Monitor and receiver model: a 2-digit sentence builder acting on the
  // falling edge of new_val.
  initial begin
    logic       prev_nv;
    logic       prev_kv;
    logic [3:0] prev_bcd;
    prev_nv = 1'b0; prev_kv = 1'b0; prev_bcd = 4'd0; rx = 8'd0;
    forever begin
      @(negedge clk);
      if (reset) begin
        rx = 8'd0;
      end else begin
        if (new_val && !prev_nv) begin
          n_rise++;
          check("setup_kv", 32'(prev_kv), 32'd1);
          check("setup_bcd", 32'(bcd), 32'(prev_bcd));
        end
        if (!new_val && prev_nv && key_valid) begin
          obs_code.push_back(int'(bcd));
          obs_kbr.push_back(int'(kb_reset));
          obs_fall.push_back(cyc);
          if (kb_reset) rx = 8'd0;
          else          rx = {rx[3:0], bcd};
        end
        if (done) begin n_done++; done_cyc = cyc; end
        if (err)  begin n_err++;  err_cyc  = cyc; end
        if (busy) busy_seen = 1'b1;
      end
      prev_nv  = new_val;
      prev_kv  = key_valid;
      prev_bcd = bcd;
    end
  end

  task automatic clear_obs();
    obs_code.delete();
    obs_kbr.delete();
    obs_fall.delete();
    n_rise = 0; n_done = 0; n_err = 0; busy_seen = 1'b0;
    done_cyc = 0; err_cyc = 0;
  endtask

  task automatic run_value(input int v, input bit mid_start);
    int unsigned t0;
    int          tens;
    int          ones;
    int          nk;
    int          per;
    int          exp_code[$];
    clear_obs();
    @(negedge clk);
    value = v[7:0];
    start = 1'b1;
    t0    = cyc;
    @(negedge clk);
    start = 1'b0;
    value = 8'($urandom);
    if (mid_start) begin
      repeat (12) @(negedge clk);
      value = 8'd12;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    for (int i = 0; i < 300 && n_done == 0 && n_err == 0; i++) @(negedge clk);
    repeat (6) @(negedge clk);

    if (v > 99) begin
      check("err_count", 32'(n_err), 32'd1);
      check("err_cycle", err_cyc, t0 + 1);
      check("err_no_strobe", 32'(n_rise), 32'd0);
      check("err_no_busy", 32'(busy_seen), 32'd0);
      check("err_no_done", 32'(n_done), 32'd0);
    end else begin
      tens = v / 10;
      ones = v % 10;
      exp_code.push_back(12);
`ifdef LEADING_ZERO_SUPPRESS_EN
      if (tens != 0) exp_code.push_back(tens);
`else
      exp_code.push_back(tens);
`endif
      exp_code.push_back(ones);
      nk  = exp_code.size();
      per = 1 + P + G;
      check("done_count", 32'(n_done), 32'd1);
      check("done_cycle", done_cyc, t0 + 32'(1 + (tens + 1) + nk * per));
      check("strobe_count", 32'(n_rise), 32'(nk));
      check("key_count", 32'(obs_code.size()), 32'(nk));
      for (int i = 0; i < nk && i < obs_code.size(); i++) begin
        check("key_code", 32'(obs_code[i]), 32'(exp_code[i]));
        check("key_kbr", 32'(obs_kbr[i]), (i == 0) ? 32'd1 : 32'd0);
        check("key_fall_cycle", obs_fall[i], t0 + 32'(tens + 3 + i * per + P));
      end
      check("rx_value", 32'(rx), 32'({tens[3:0], ones[3:0]}));
      check("no_err", 32'(n_err), 32'd0);
      check("busy_idle", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    value = 8'd0;
    clear_obs();
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({bcd, key_valid, new_val, kb_reset, busy, done, err}), 32'd0);
    reset = 1'b0;

    run_value(47, 1'b0);
    run_value(5, 1'b0);
    run_value(0, 1'b0);
    run_value(99, 1'b0);
    run_value(100, 1'b0);
    run_value(255, 1'b0);
    run_value(47, 1'b1);

    // Reset during the second keystroke's pulse, then a clean run.
    clear_obs();
    @(negedge clk);
    value = 8'd47;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 100 && n_rise < 2; i++) @(negedge clk);
    check("in_second_pulse", 32'({n_rise[7:0], new_val}), 32'({8'd2, 1'b1}));
    reset = 1'b1;
    @(negedge clk);
    check("midrun_reset_outputs", 32'({bcd, key_valid, new_val, kb_reset, busy, done, err}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run_value(36, 1'b0);

    repeat (25) run_value(int'($urandom_range(0, 110)), 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bcd_keystroke_player.md
# bcd_keystroke_player

Transmit-side counterpart of the keypad digit-entry path. Accepts an 8-bit binary value (0–99), converts it to two BCD digits, and replays it as the keystroke sequence the 2-digit sentence builder expects: a clear keystroke, then tens digit, then ones digit, each framed by a falling-edge `new_val` strobe. Used to load ALU results back into operand registers and as a stimulus source for keypad-path verification.

## Interface
- `PULSE_CYCLES`, default 4: clock cycles `new_val` is held high per keystroke (≥1).
- `GAP_CYCLES`, default 4: cycles `bcd`/`key_valid` are held after `new_val` falls (≥1).
- `clk` input 1: 100 MHz system clock; all logic on rising edge.
- `reset` input 1: reset, synchronous, active-high.
- `start` input 1: one-cycle request; sampled only in IDLE.
- `value` input 8: binary value, captured on accepted `start`.
- `bcd` output 4: keystroke code (digit 0–9, or 4'hC for clear).
- `key_valid` output 1: keystroke code valid; maps to receiver `valid`.
- `new_val` output 1: keystroke strobe; receiver acts on its falling edge.
- `kb_reset` output 1: asserted with the clear keystroke; maps to receiver `reset`.
- `busy` output 1: high from accepted `start` until DONE exits.
- `done` output 1: one-cycle pulse after final keystroke's gap.
- `err` output 1: one-cycle pulse when captured value > 99.

## Operation
- States: IDLE, CONV, KEY_SETUP, KEY_PULSE, KEY_HOLD, DONE.
- IDLE: `start`=1 captures `value` into `rem`, clears `tens`; if `value` > 99 → pulse `err` next cycle, stay IDLE, no keystrokes, `busy` stays 0. Else → CONV, `busy`=1.
- CONV: each cycle, if `rem` ≥ 10: `rem` −= 10, `tens` += 1; else ones = `rem`, key index k=0 → KEY_SETUP. `tens` 4-bit, `rem` 7-bit; never exceeds 9 / 99.
- Keystroke list: k=0 clear (`bcd`=4'hC, `kb_reset`=1); k=1 tens digit; k=2 ones digit (`kb_reset`=0).
- KEY_SETUP (1 cycle): drive `bcd`, `kb_reset`, `key_valid`=1, `new_val`=0 → KEY_PULSE.
- KEY_PULSE: `new_val`=1 for PULSE_CYCLES cycles, code lines stable → KEY_HOLD.
- KEY_HOLD: `new_val`=0, code lines held GAP_CYCLES cycles; then `key_valid`=0, `kb_reset`=0, `bcd`=0; if k<2 → k+1, KEY_SETUP; else → DONE.
- DONE (1 cycle): `done`=1, `busy` drops the following cycle → IDLE.
- `start` while `busy`=1 ignored; `value` changes after capture ignored.
- Backspace code (4'hD) never emitted.

## Timing
- Reset values: `bcd`=0, `key_valid`=0, `new_val`=0, `kb_reset`=0, `busy`=0, `done`=0, `err`=0; state IDLE, counters 0.
- `busy` rises the cycle after accepted `start`.
- CONV latency: tens+1 cycles (1–10).
- Per keystroke: 1 + PULSE_CYCLES + GAP_CYCLES cycles (9 at defaults).
- Total start→`done`: 1 + (tens+1) + n_keys×(1+PULSE+GAP) cycles; n_keys = 3 (or 2 with suppression).
- `bcd`, `key_valid`, `kb_reset` stable for ≥1 cycle before `new_val` rises and ≥GAP_CYCLES after it falls.
- `err` fires the cycle after `start` with out-of-range value.
- Reset mid-operation: all outputs to reset values at the next edge; if in KEY_PULSE, `new_val` falls with `key_valid` — receiver must be reset by the same system reset; no recovery of partial sequence.

## Configuration
- `LEADING_ZERO_SUPPRESS_EN` defined: when tens = 0, keystroke k=1 skipped (KEY_HOLD of clear → k=2 directly); sequence is clear, ones.
- Undefined: tens digit always sent, including 0; always 3 keystrokes.

## Test plan
- `value`=47 → keystrokes C (kb_reset=1), 4, 7; 3 falling `new_val` edges; connected receiver output = 8'h47; `done` at cycle 1+5+27=33 after start.
- `value`=5 → with macro: C, 5 (2 strobes); without: C, 0, 5; receiver output 8'h05 in both builds.
- `value`=100 and 255 → `err` one-cycle pulse, `new_val` never rises, `busy` stays 0.
- `value`=0 and 99 → receiver output 8'h00 / 8'h99; CONV takes 1 / 10 cycles.
- `start` pulsed again mid-sequence with `value`=12 → ignored; original sequence completes unchanged, one `done`.
- `reset` asserted during second KEY_PULSE → all outputs 0 next edge, state IDLE; new `start` with 36 then completes normally.
